trap_ctrl: RTL and testbench
============================

Name: trap_ctrl

Overview:
Sequences the LC-3b TRAP instruction. It zero-extends trapvect8 and shifts it into a vector-table word address, then saves the return PC to R7. It reads the service-routine address from memory over a req/ready handshake and loads it into the PC. It sits between the control store / decode logic and the memory, register-file and PC write ports, and owns the zero-extension path for the vector.

Parameters:
ADDR_SHIFT, 1, left shift applied to the zero-extended vector (1 = byte-addressed word table).
TIMEOUT, 255, max cycles to wait for mem_ready before aborting; 0 disables the timeout (wait forever).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  TRAP request; sampled only in IDLE.
trapvect8  in  8  trap vector from IR[7:0]; sampled with start.
pc_in  in  16  incremented PC; sampled with start.
busy  out  1  high in any state other than IDLE.
mem_req  out  1  memory read request.
mem_addr  out  16  vector-table address.
mem_rdata  in  16  memory read data, valid when mem_ready=1.
mem_ready  in  1  memory read completion.
r7_we  out  1  R7 write enable, one-cycle pulse.
r7_data  out  16  value to write to R7.
pc_we  out  1  PC load enable, one-cycle pulse.
pc_data  out  16  new PC value.
done  out  1  one-cycle pulse on successful completion.
err  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. Every output is 0, including mem_addr, r7_data and pc_data. Timeout counter is 0.
- States: IDLE, SAVE, FETCH, LOAD.
- IDLE: if start=1 at edge N, latch pc_in to ret_pc and latch vec_addr = zext(trapvect8) << ADDR_SHIFT (16 bits, upper bits zero). Move to SAVE.
- SAVE (cycle N+1): r7_we=1 and r7_data=ret_pc for exactly one cycle. Next state FETCH. Clear the timeout counter.
- FETCH: mem_req=1 and mem_addr=vec_addr, held stable until the handshake completes.
  - mem_ready=1 at an edge: capture mem_rdata, deassert mem_req next cycle, go to LOAD.
  - mem_ready=0: counter increments.
  - TIMEOUT != 0 and counter reaches TIMEOUT-1 with mem_ready still 0: pulse err=1 next cycle, no pc_we, return to IDLE.
  - mem_ready and the timeout in the same cycle: mem_ready wins.
- LOAD: pc_we=1, pc_data=captured word and done=1, all for one cycle. Next state IDLE.
- Latency: with mem_ready high in the first FETCH cycle, start at edge N gives r7_we at N+1, mem_req at N+2 and pc_we/done at N+3. The start-to-start throughput minimum is 4 cycles.
- start while busy: ignored, not queued. trapvect8 and pc_in changes while busy have no effect.
- mem_ready outside FETCH: ignored.
- mem_addr, r7_data and pc_data hold their last value when not strobed. Consumers use the strobes only.
- Boundary vectors:
  - trapvect8=0x00 gives 0x0000.
  - trapvect8=0xFF gives 0x01FE with ADDR_SHIFT=1.
  - No sign extension ever: 0x80 gives 0x0100, not 0xFF00.
- Reset mid-operation: immediate return to IDLE with all strobes low. A pending mem_req drops asynchronously. No partial R7 or PC write is completed after reset.
- err and done are mutually exclusive per operation.

Decomposition:
- Shared package lc3b_pkg: state encoding constants (IDLE=2'd0, SAVE=2'd1, FETCH=2'd2, LOAD=2'd3), R7 index constant 3'd7, WORD_W=16.
- Sub-module: the existing zext block is instantiated for vector extension. The shift is done in trap_ctrl.
- Timeout counter width is derived from TIMEOUT (ceil log2, minimum 1).

Test Plan:
- Reset, then start with trapvect8=0x25 and pc_in=0x3002; memory returns 0x0520 on the first FETCH cycle -> r7_we with r7_data=0x3002 at N+1; mem_addr=0x004A; pc_we/done with pc_data=0x0520 at N+3.
- trapvect8=0xFF and 0x80 -> mem_addr=0x01FE and 0x0100 (no sign extension).
- mem_ready delayed 7 cycles after mem_req rises -> mem_req and mem_addr stay stable for 7 cycles, busy=1 throughout, pc_we exactly one cycle after ready.
- TIMEOUT=4 with mem_ready never asserted -> err pulses once; no pc_we or done; busy=0 the following cycle; R7 was still written in SAVE.
- start held high for 10 cycles -> exactly one trap operation; a second start pulse issued during FETCH is ignored.
- rst_n asserted low during FETCH -> mem_req and busy drop immediately, no pc_we/done; a new start after release operates normally.

Source files
------------

// File: rtl/lc3b_pkg.sv
// Shared LC-3b control definitions.
//   WORD_W       datapath word width
//   R7_IDX       register-file index of the TRAP link register
//   trap_state_e TRAP sequencer state encoding
//   cnt_width()  bit width of a counter that must reach limit-1 (minimum 1)
package lc3b_pkg;

   localparam int WORD_W = 16;
   localparam logic [2:0] R7_IDX = 3'd7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SAVE  = 2'd1,
      FETCH = 2'd2,
      LOAD  = 2'd3
   } trap_state_e;

   function automatic int cnt_width(input int limit);
      if (limit <= 2) return 1;
      return $clog2(limit);
   endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Memory read handshake between the TRAP sequencer and the memory.
//   mem_req   request, held until mem_ready is seen
//   mem_addr  vector-table word address
//   mem_rdata read data, valid with mem_ready
//   mem_ready read completion
// master: the sequencer side; slave: the memory side.
interface trap_ctrl_if;

   logic                      mem_req;
   logic [lc3b_pkg::WORD_W-1:0] mem_addr;
   logic [lc3b_pkg::WORD_W-1:0] mem_rdata;
   logic                      mem_ready;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_rdata,
      input  mem_ready
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_rdata,
      output mem_ready
   );

endinterface

// File: rtl/trap_ctrl_zext.sv
// Zero-extension of a narrow field to a wider word.
//   din   IN_W-bit input field
//   dout  OUT_W-bit result, upper bits zero
module trap_ctrl_zext #(
   parameter int IN_W  = 8,
   parameter int OUT_W = 16
) (
   input  logic [IN_W-1:0]  din,
   output logic [OUT_W-1:0] dout
);

   assign dout = {{(OUT_W-IN_W){1'b0}}, din};

endmodule

// File: rtl/trap_ctrl.sv
// LC-3b TRAP sequencer: saves the return PC to R7, reads the service-routine
// address from the vector table and loads it into the PC.
//   clk, rst_n          clock, async active-low reset
//   start               TRAP request (accepted only in IDLE)
//   trapvect8, pc_in    vector and incremented PC, captured with start
//   busy                high whenever not IDLE
//   mem                 vector-table read handshake (master side)
//   r7_we, r7_data      R7 write strobe and data
//   pc_we, pc_data      PC load strobe and data
//   done, err           completion / timeout-abort pulses
//
// state | meaning
// IDLE  | waiting for start
// SAVE  | r7_we strobed with the return PC
// FETCH | mem_req held until mem_ready or timeout
// LOAD  | pc_we and done strobed with the fetched address
module trap_ctrl
   import lc3b_pkg::*;
#(
   parameter int ADDR_SHIFT = 1,
   parameter int TIMEOUT    = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [7:0]        trapvect8,
   input  logic [WORD_W-1:0] pc_in,
   output logic              busy,
   trap_ctrl_if.master       mem,
   output logic              r7_we,
   output logic [WORD_W-1:0] r7_data,
   output logic              pc_we,
   output logic [WORD_W-1:0] pc_data,
   output logic              done,
   output logic              err
);

   localparam int CNT_W = cnt_width(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam bit TO_EN = (TIMEOUT != 0);

   trap_state_e       state;
   logic [CNT_W-1:0]  wait_cnt;
   logic [WORD_W-1:0] vec_addr;
   logic [WORD_W-1:0] vec_ext;
   logic [WORD_W-1:0] vec_shifted;

   trap_ctrl_zext #(
      .IN_W  (8),
      .OUT_W (WORD_W)
   ) u_zext (
      .din  (trapvect8),
      .dout (vec_ext)
   );

   assign vec_shifted = vec_ext << ADDR_SHIFT;

   // r7_data doubles as the latched return PC; it is loaded on the start edge
   // so that it is already valid while r7_we is high in SAVE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         wait_cnt     <= '0;
         vec_addr     <= '0;
         busy         <= 1'b0;
         mem.mem_req  <= 1'b0;
         mem.mem_addr <= '0;
         r7_we        <= 1'b0;
         r7_data      <= '0;
         pc_we        <= 1'b0;
         pc_data      <= '0;
         done         <= 1'b0;
         err          <= 1'b0;
      end else begin
         r7_we <= 1'b0;
         pc_we <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  vec_addr <= vec_shifted;
                  r7_data  <= pc_in;
                  r7_we    <= 1'b1;
                  busy     <= 1'b1;
                  state    <= SAVE;
               end
            end
            SAVE: begin
               wait_cnt     <= '0;
               mem.mem_req  <= 1'b1;
               mem.mem_addr <= vec_addr;
               state        <= FETCH;
            end
            FETCH: begin
               // ready is checked first so a completion on the last allowed
               // cycle still counts as success.
               if (mem.mem_ready) begin
                  mem.mem_req <= 1'b0;
                  pc_data     <= mem.mem_rdata;
                  pc_we       <= 1'b1;
                  done        <= 1'b1;
                  state       <= LOAD;
               end else if (TO_EN && (wait_cnt == CNT_LAST)) begin
                  mem.mem_req <= 1'b0;
                  err         <= 1'b1;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            LOAD: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy        <= 1'b0;
               mem.mem_req <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start_a;
   logic        start_b;
   logic [7:0]  trapvect8;
   logic [15:0] pc_in;

   logic        busy_a, r7_we_a, pc_we_a, done_a, err_a;
   logic [15:0] r7_data_a, pc_data_a;
   logic        busy_b, r7_we_b, pc_we_b, done_b, err_b;
   logic [15:0] r7_data_b, pc_data_b;

   int checks = 0;
   int errors = 0;

   trap_ctrl_if mif_a ();
   trap_ctrl_if mif_b ();

   trap_ctrl #(.ADDR_SHIFT(1), .TIMEOUT(255)) dut_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start_a),
      .trapvect8 (trapvect8),
      .pc_in     (pc_in),
      .busy      (busy_a),
      .mem       (mif_a),
      .r7_we     (r7_we_a),
      .r7_data   (r7_data_a),
      .pc_we     (pc_we_a),
      .pc_data   (pc_data_a),
      .done      (done_a),
      .err       (err_a)
   );

   trap_ctrl #(.ADDR_SHIFT(1), .TIMEOUT(4)) dut_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start_b),
      .trapvect8 (trapvect8),
      .pc_in     (pc_in),
      .busy      (busy_b),
      .mem       (mif_b),
      .r7_we     (r7_we_b),
      .r7_data   (r7_data_b),
      .pc_we     (pc_we_b),
      .pc_data   (pc_data_b),
      .done      (done_b),
      .err       (err_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [15:0] outs_a;
      logic [15:0] outs_b;
      rst_n = 1'b0;
      start_a = 1'b0;
      start_b = 1'b0;
      trapvect8 = 8'h00;
      pc_in = 16'h0000;
      mif_a.mem_ready = 1'b0;
      mif_a.mem_rdata = 16'h0000;
      mif_b.mem_ready = 1'b0;
      mif_b.mem_rdata = 16'h0000;
      tick();
      tick();
      outs_a = {9'd0, busy_a, mif_a.mem_req, r7_we_a, pc_we_a, done_a, err_a, 1'b0};
      outs_b = {9'd0, busy_b, mif_b.mem_req, r7_we_b, pc_we_b, done_b, err_b, 1'b0};
      checks++; if (outs_a !== 16'h0000) begin errors++; $display("FAIL reset_strobes_a: got %h expected 0000", outs_a); end
      checks++; if (outs_b !== 16'h0000) begin errors++; $display("FAIL reset_strobes_b: got %h expected 0000", outs_b); end
      checks++; if (mif_a.mem_addr !== 16'h0000) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0000", mif_a.mem_addr); end
      checks++; if (r7_data_a !== 16'h0000) begin errors++; $display("FAIL reset_r7_data: got %h expected 0000", r7_data_a); end
      checks++; if (pc_data_a !== 16'h0000) begin errors++; $display("FAIL reset_pc_data: got %h expected 0000", pc_data_a); end
      rst_n = 1'b1;
      tick();
      checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy got %b expected 0", busy_a); end
   endtask

   task automatic test_basic();
      trapvect8 = 8'h25;
      pc_in = 16'h3002;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      checks++; if (r7_we_a !== 1'b1) begin errors++; $display("FAIL basic_r7_we: got %b expected 1", r7_we_a); end
      checks++; if (r7_data_a !== 16'h3002) begin errors++; $display("FAIL basic_r7_data: got %h expected 3002", r7_data_a); end
      checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy_a); end
      checks++; if (mif_a.mem_req !== 1'b0) begin errors++; $display("FAIL basic_req_early: got %b expected 0", mif_a.mem_req); end
      tick();
      checks++; if (r7_we_a !== 1'b0) begin errors++; $display("FAIL basic_r7_pulse: got %b expected 0", r7_we_a); end
      checks++; if (mif_a.mem_req !== 1'b1) begin errors++; $display("FAIL basic_mem_req: got %b expected 1", mif_a.mem_req); end
      checks++; if (mif_a.mem_addr !== 16'h004A) begin errors++; $display("FAIL basic_mem_addr: got %h expected 004a", mif_a.mem_addr); end
      mif_a.mem_ready = 1'b1;
      mif_a.mem_rdata = 16'h0520;
      tick();
      mif_a.mem_ready = 1'b0;
      checks++; if ({pc_we_a, done_a, err_a} !== 3'b110) begin errors++; $display("FAIL basic_pc_we_done: got %b expected 110", {pc_we_a, done_a, err_a}); end
      checks++; if (pc_data_a !== 16'h0520) begin errors++; $display("FAIL basic_pc_data: got %h expected 0520", pc_data_a); end
      checks++; if (mif_a.mem_req !== 1'b0) begin errors++; $display("FAIL basic_req_drop: got %b expected 0", mif_a.mem_req); end
      tick();
      checks++; if ({busy_a, pc_we_a, done_a} !== 3'b000) begin errors++; $display("FAIL basic_end: got %b expected 000", {busy_a, pc_we_a, done_a}); end
   endtask

   task automatic test_vectors();
      logic [7:0]  vecs [3] = '{8'h00, 8'hFF, 8'h80};
      logic [15:0] addrs[3] = '{16'h0000, 16'h01FE, 16'h0100};
      logic [15:0] words[3] = '{16'h1000, 16'h2468, 16'hFFFF};
      for (int i = 0; i < 3; i++) begin
         trapvect8 = vecs[i];
         pc_in = 16'h0100 + 16'(i);
         start_a = 1'b1;
         tick();
         start_a = 1'b0;
         tick();
         checks++; if (mif_a.mem_addr !== addrs[i]) begin errors++; $display("FAIL vec_addr_%0d: got %h expected %h", i, mif_a.mem_addr, addrs[i]); end
         mif_a.mem_ready = 1'b1;
         mif_a.mem_rdata = words[i];
         tick();
         mif_a.mem_ready = 1'b0;
         checks++; if (pc_data_a !== words[i] || pc_we_a !== 1'b1) begin errors++; $display("FAIL vec_pc_%0d: got %h/%b expected %h/1", i, pc_data_a, pc_we_a, words[i]); end
         tick();
      end
   endtask

   task automatic test_wait();
      trapvect8 = 8'h10;
      pc_in = 16'h1234;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      tick();
      for (int i = 0; i < 7; i++) begin
         // disturb inputs while busy; none of this may leak into the operation
         trapvect8 = 8'h77;
         pc_in = 16'hAAAA;
         start_a = (i == 2);
         tick();
         checks++; if ({busy_a, mif_a.mem_req, pc_we_a, r7_we_a} !== 4'b1100) begin errors++; $display("FAIL wait_hold_%0d: got %b expected 1100", i, {busy_a, mif_a.mem_req, pc_we_a, r7_we_a}); end
         checks++; if (mif_a.mem_addr !== 16'h0020) begin errors++; $display("FAIL wait_addr_%0d: got %h expected 0020", i, mif_a.mem_addr); end
      end
      start_a = 1'b0;
      mif_a.mem_ready = 1'b1;
      mif_a.mem_rdata = 16'hBEEF;
      tick();
      mif_a.mem_ready = 1'b0;
      checks++; if ({pc_we_a, done_a} !== 2'b11 || pc_data_a !== 16'hBEEF) begin errors++; $display("FAIL wait_load: got %b/%h expected 11/beef", {pc_we_a, done_a}, pc_data_a); end
      checks++; if (r7_data_a !== 16'h1234) begin errors++; $display("FAIL wait_r7_kept: got %h expected 1234", r7_data_a); end
      tick();
      checks++; if ({busy_a, pc_we_a} !== 2'b00) begin errors++; $display("FAIL wait_end: got %b expected 00", {busy_a, pc_we_a}); end
   endtask

   task automatic test_timeout();
      int pc_seen = 0;
      trapvect8 = 8'h03;
      pc_in = 16'h4000;
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      checks++; if (r7_we_b !== 1'b1 || r7_data_b !== 16'h4000) begin errors++; $display("FAIL to_r7: got %b/%h expected 1/4000", r7_we_b, r7_data_b); end
      tick();
      checks++; if (mif_b.mem_req !== 1'b1 || mif_b.mem_addr !== 16'h0006) begin errors++; $display("FAIL to_req: got %b/%h expected 1/0006", mif_b.mem_req, mif_b.mem_addr); end
      for (int i = 1; i <= 5; i++) begin
         tick();
         pc_seen += int'(pc_we_b) + int'(done_b);
         if (i < 4) begin
            checks++; if ({err_b, mif_b.mem_req, busy_b} !== 3'b011) begin errors++; $display("FAIL to_wait_%0d: got %b expected 011", i, {err_b, mif_b.mem_req, busy_b}); end
         end else if (i == 4) begin
            checks++; if ({err_b, mif_b.mem_req, busy_b} !== 3'b100) begin errors++; $display("FAIL to_err: got %b expected 100", {err_b, mif_b.mem_req, busy_b}); end
         end else begin
            checks++; if ({err_b, busy_b} !== 2'b00) begin errors++; $display("FAIL to_err_pulse: got %b expected 00", {err_b, busy_b}); end
         end
      end
      checks++; if (pc_seen !== 0) begin errors++; $display("FAIL to_no_pc_we: got %0d expected 0", pc_seen); end
   endtask

   task automatic test_start_held();
      int r7_seen = 0;
      trapvect8 = 8'h41;
      pc_in = 16'h5000;
      start_a = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         r7_seen += int'(r7_we_a);
         if (i == 9) start_a = 1'b0;
      end
      checks++; if (r7_seen !== 1) begin errors++; $display("FAIL held_one_op: got %0d expected 1", r7_seen); end
      checks++; if ({busy_a, mif_a.mem_req} !== 2'b11 || mif_a.mem_addr !== 16'h0082) begin errors++; $display("FAIL held_fetch: got %b/%h expected 11/0082", {busy_a, mif_a.mem_req}, mif_a.mem_addr); end
      mif_a.mem_ready = 1'b1;
      mif_a.mem_rdata = 16'h1111;
      tick();
      mif_a.mem_ready = 1'b0;
      checks++; if (pc_we_a !== 1'b1 || pc_data_a !== 16'h1111) begin errors++; $display("FAIL held_load: got %b/%h expected 1/1111", pc_we_a, pc_data_a); end
      tick();
      r7_seen += int'(r7_we_a);
      tick();
      r7_seen += int'(r7_we_a);
      checks++; if (busy_a !== 1'b0 || r7_seen !== 1) begin errors++; $display("FAIL held_end: got %b/%0d expected 0/1", busy_a, r7_seen); end
   endtask

   task automatic test_back_to_back();
      logic exp_r7;
      logic exp_pc;
      trapvect8 = 8'h22;
      pc_in = 16'h6000;
      mif_a.mem_ready = 1'b1;
      mif_a.mem_rdata = 16'h7777;
      start_a = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (i == 4) start_a = 1'b0;
         exp_r7 = (i == 0) || (i == 4);
         exp_pc = (i == 2) || (i == 6);
         checks++; if ({r7_we_a, pc_we_a, done_a} !== {exp_r7, exp_pc, exp_pc}) begin errors++; $display("FAIL b2b_cycle_%0d: got %b expected %b", i, {r7_we_a, pc_we_a, done_a}, {exp_r7, exp_pc, exp_pc}); end
      end
      mif_a.mem_ready = 1'b0;
      checks++; if (busy_a !== 1'b0 || mif_a.mem_addr !== 16'h0044) begin errors++; $display("FAIL b2b_end: got %b/%h expected 0/0044", busy_a, mif_a.mem_addr); end
   endtask

   task automatic test_reset_mid();
      trapvect8 = 8'h30;
      pc_in = 16'h7000;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if ({mif_a.mem_req, busy_a, pc_we_a, done_a, r7_we_a} !== 5'b00000) begin errors++; $display("FAIL rst_mid_drop: got %b expected 00000", {mif_a.mem_req, busy_a, pc_we_a, done_a, r7_we_a}); end
      checks++; if (mif_a.mem_addr !== 16'h0000 || r7_data_a !== 16'h0000) begin errors++; $display("FAIL rst_mid_data: got %h/%h expected 0000/0000", mif_a.mem_addr, r7_data_a); end
      mif_a.mem_ready = 1'b1;
      mif_a.mem_rdata = 16'hDEAD;
      tick();
      rst_n = 1'b1;
      tick();
      checks++; if ({pc_we_a, done_a, busy_a} !== 3'b000 || pc_data_a !== 16'h0000) begin errors++; $display("FAIL rst_mid_no_load: got %b/%h expected 000/0000", {pc_we_a, done_a, busy_a}, pc_data_a); end
      mif_a.mem_ready = 1'b0;
      trapvect8 = 8'h25;
      pc_in = 16'h3002;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      checks++; if (r7_we_a !== 1'b1 || r7_data_a !== 16'h3002) begin errors++; $display("FAIL rst_mid_restart_r7: got %b/%h expected 1/3002", r7_we_a, r7_data_a); end
      tick();
      mif_a.mem_ready = 1'b1;
      mif_a.mem_rdata = 16'h0520;
      tick();
      mif_a.mem_ready = 1'b0;
      checks++; if (pc_we_a !== 1'b1 || pc_data_a !== 16'h0520) begin errors++; $display("FAIL rst_mid_restart_pc: got %b/%h expected 1/0520", pc_we_a, pc_data_a); end
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_vectors();
      test_wait();
      test_timeout();
      test_start_held();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
